uc_float: RTL and testbench

Control unit for the floating-point add/multiply datapath. Sequences one operation per `start`: selects the larger operand, drives the alignment shift, runs the shift-add multiplier for its fixed cycle count, and normalizes from `ula`. It also detects a rounding carry from `round_fract` and finishes with a registered rounding pass. It sits beside the datapath: its outputs are the datapath's `sinal*` control inputs, and its status inputs are the datapath's `exp_dif`, `ula` and `round_fract` outputs.

---
 rtl/uc_float_pkg.sv | 38 +++
 rtl/uc_float_lzc27.sv | 26 ++
 rtl/uc_float.sv | 215 +++++++++++++++++++++
 tb/tb_uc_float.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uc_float_pkg.sv
//------------------------------------------------------------------------------
// uc_float_pkg
// Shared constants and the state encoding for the floating-point control unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uc_float_pkg;

    // Cycles spent in MULT_WAIT after the multiplier reset pulse.
    localparam int MULT_CYCLES = 28;

    // Saturation value for the alignment shift.
    localparam int SHIFT_MAX = 27;

    // Operation encodings; anything other than OP_ADD runs as a multiply.
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;

    // Result shift / exponent adjust codes: bit8 selects direction.
    localparam logic [8:0] SH_CLEAR = 9'h01B;   // right 27, clears the fraction
    localparam logic [8:0] SH_L1    = 9'h101;   // left 1, realigns the feedback

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_EXP       = 4'd1,
        ST_ALIGN     = 4'd2,
        ST_MULT_INIT = 4'd3,
        ST_MULT_WAIT = 4'd4,
        ST_NORM      = 4'd5,
        ST_CHECK     = 4'd6,
        ST_FINAL     = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uc_float_lzc27.sv
//------------------------------------------------------------------------------
// lzc27
// Combinational leading-zero counter for a 27-bit magnitude. An all-zero
// input reports 27; the caller treats that case separately.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lzc27 (
    input  logic [26:0] value_i,
    output logic [4:0]  count_o
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value_i[i]) begin
                count_o = 5'(26 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uc_float.sv
//------------------------------------------------------------------------------
// uc_float
// Control unit for the floating-point add/multiply datapath. Sequences one
// operation per start: operand select, alignment, multiplier wait,
// normalization, rounding-carry check and a final rounding pass.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uc_float
    import uc_float_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [7:0]  exp_dif,
    input  logic [26:0] ula,
    input  logic [25:0] round_fract,
    output logic        sinalMuxFP1,
    output logic        sinalMuxFP2,
    output logic        sinalMuxFP3,
    output logic        sinalMuxFP4,
    output logic        sinalMuxFP5,
    output logic [7:0]  sinalShiftFract,
    output logic [8:0]  sinalShiftRes,
    output logic [8:0]  sinalIncOrDec,
    output logic        sinalRound,
    output logic        mult_reset,
    output logic        busy,
    output logic        done,
    output logic        zero
);

    state_t      state_q, state_d;
    logic        op_add_q, op_add_d;
    logic [7:0]  exp_a_q, exp_a_d;
    logic [7:0]  exp_b_q, exp_b_d;
    logic        sel_b_q, sel_b_d;
    logic [7:0]  shift_q, shift_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [4:0]  lz;
    logic        w_sel_b;
    logic [7:0]  w_shift_sat;
    logic        w_ula_zero;
    logic        w_carry;
    logic        w_carry_use;
    logic        w_unused_rf;

    lzc27 u_lzc27 (
        .value_i (ula),
        .count_o (lz)
    );

    assign w_sel_b     = (exp_b_q > exp_a_q);
    assign w_shift_sat = (exp_dif > 8'(SHIFT_MAX)) ? 8'(SHIFT_MAX) : exp_dif;
    assign w_ula_zero  = (ula == 27'd0);
    // A carry out of rounding needs every retained bit set plus the round bit;
    // a zero result never rounds.
    assign w_carry     = (&round_fract[25:3]) & round_fract[2] & ~zero_q;
    assign w_unused_rf = ^round_fract[1:0];

    // State and captured-field registers; reset abandons any operation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_add_q <= 1'b0;
            exp_a_q  <= 8'd0;
            exp_b_q  <= 8'd0;
            sel_b_q  <= 1'b0;
            shift_q  <= 8'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            op_add_q <= op_add_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            sel_b_q  <= sel_b_d;
            shift_q  <= shift_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state sequencing and field updates.
    always_comb begin
        state_d  = state_q;
        op_add_d = op_add_q;
        exp_a_d  = exp_a_q;
        exp_b_d  = exp_b_q;
        sel_b_d  = sel_b_q;
        shift_d  = shift_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_add_d = (op == OP_ADD);
                    exp_a_d  = exp_a;
                    exp_b_d  = exp_b;
                    zero_d   = 1'b0;
                    carry_d  = 1'b0;
                    shift_d  = 8'd0;   // multiply never aligns
                    cnt_d    = 5'd0;
                    state_d  = ST_EXP;
                end
            end
            ST_EXP: begin
                sel_b_d = w_sel_b;
                state_d = op_add_q ? ST_ALIGN : ST_MULT_INIT;
            end
            ST_ALIGN: begin
                shift_d = w_shift_sat;
                state_d = ST_NORM;
            end
            ST_MULT_INIT: begin
                cnt_d   = 5'd0;
                state_d = ST_MULT_WAIT;
            end
            ST_MULT_WAIT: begin
                if (cnt_q == 5'(MULT_CYCLES - 1)) begin
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_NORM: begin
                if (w_ula_zero) begin
                    zero_d = 1'b1;
                end
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                carry_d = w_carry;
                state_d = ST_FINAL;
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // In CHECK the carry register is still loading, so use the live value.
    assign w_carry_use = (state_q == ST_CHECK) ? w_carry : carry_q;

    // Datapath control decode from the state and registered fields.
    always_comb begin
        sinalMuxFP1     = 1'b0;
        sinalMuxFP2     = 1'b0;
        sinalMuxFP3     = 1'b0;
        sinalMuxFP4     = 1'b0;
        sinalMuxFP5     = 1'b0;
        sinalShiftFract = 8'd0;
        sinalShiftRes   = 9'd0;
        sinalIncOrDec   = 9'd0;
        sinalRound      = 1'b0;
        mult_reset      = 1'b0;
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_DONE);
        zero            = zero_q | ((state_q == ST_NORM) & w_ula_zero);

        if (state_q == ST_EXP) begin
            sinalMuxFP1 = w_sel_b;
            sinalMuxFP2 = w_sel_b;
            sinalMuxFP3 = ~w_sel_b;
        end else if (state_q != ST_IDLE) begin
            sinalMuxFP1 = sel_b_q;
            sinalMuxFP2 = sel_b_q;
            sinalMuxFP3 = ~sel_b_q;
        end

        case (state_q)
            ST_ALIGN: begin
                sinalShiftFract = w_shift_sat;
            end
            ST_MULT_INIT: begin
                mult_reset = 1'b1;
            end
            ST_NORM: begin
                sinalShiftFract = shift_q;
                if (w_ula_zero) begin
                    sinalShiftRes = SH_CLEAR;
                end else begin
                    sinalShiftRes = {1'b1, 3'b000, lz};
                    sinalIncOrDec = {1'b1, 3'b000, lz};
                end
            end
            ST_CHECK, ST_FINAL, ST_DONE: begin
                sinalShiftFract = shift_q;
                sinalMuxFP4     = 1'b1;
                sinalMuxFP5     = 1'b1;
                if (w_carry_use) begin
                    sinalShiftRes = SH_CLEAR;
                    sinalIncOrDec = 9'h001;
                end else begin
                    sinalShiftRes = SH_L1;
                    sinalRound    = (state_q != ST_CHECK) & ~zero_q;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uc_float.sv
//------------------------------------------------------------------------------
// tb_uc_float
// Scoreboard bench for uc_float: expected results are queued when an
// operation is launched and compared when done pulses.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uc_float;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  exp_a = 8'd0;
    logic [7:0]  exp_b = 8'd0;
    logic [7:0]  exp_dif = 8'd0;
    logic [26:0] ula = 27'd0;
    logic [25:0] round_fract = 26'd0;
    logic        sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4, sinalMuxFP5;
    logic [7:0]  sinalShiftFract;
    logic [8:0]  sinalShiftRes, sinalIncOrDec;
    logic        sinalRound, mult_reset, busy, done, zero;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         lat;
        logic       sel;
        logic [7:0] sf;
        logic [8:0] nsr;
        logic [8:0] nid;
        logic       zr;
        logic [8:0] fsr;
        logic [8:0] fid;
        logic       rnd;
        int         mrst;
    } exp_t;

    exp_t sb[$];

    uc_float dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .op              (op),
        .exp_a           (exp_a),
        .exp_b           (exp_b),
        .exp_dif         (exp_dif),
        .ula             (ula),
        .round_fract     (round_fract),
        .sinalMuxFP1     (sinalMuxFP1),
        .sinalMuxFP2     (sinalMuxFP2),
        .sinalMuxFP3     (sinalMuxFP3),
        .sinalMuxFP4     (sinalMuxFP4),
        .sinalMuxFP5     (sinalMuxFP5),
        .sinalShiftFract (sinalShiftFract),
        .sinalShiftRes   (sinalShiftRes),
        .sinalIncOrDec   (sinalIncOrDec),
        .sinalRound      (sinalRound),
        .mult_reset      (mult_reset),
        .busy            (busy),
        .done            (done),
        .zero            (zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            $display("FAIL %s: got %0h required %0h", tag, got, want);
        end else begin
            n_pass++;
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [7:0] ea, input logic [7:0] eb,
                                   input logic [7:0] dif, input logic [26:0] u, input logic [25:0] rf);
        exp_t e;
        int   lz;
        logic add, carry;
        lz = 0;
        while (lz < 27 && !u[26 - lz]) lz++;
        add    = (o == 2'b00);
        e.lat  = add ? 6 : 34;
        e.mrst = add ? 0 : 1;
        e.sel  = (eb > ea);
        e.sf   = add ? ((dif > 8'd27) ? 8'd27 : dif) : 8'd0;
        e.zr   = (u == 27'd0);
        e.nsr  = e.zr ? 9'h01B : (9'h100 | 9'(lz));
        e.nid  = e.zr ? 9'h000 : (9'h100 | 9'(lz));
        carry  = (rf[25:3] == 23'h7FFFFF) && rf[2] && !e.zr;
        e.fsr  = carry ? 9'h01B : 9'h101;
        e.fid  = carry ? 9'h001 : 9'h000;
        e.rnd  = !carry && !e.zr;
        return e;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [7:0] ea, input logic [7:0] eb,
                          input logic [7:0] dif, input logic [26:0] u, input logic [25:0] rf,
                          input bit poke);
        exp_t       e;
        logic [8:0] sr_log [0:63];
        logic [8:0] id_log [0:63];
        int         cyc;
        int         mrst;
        bit         got;
        sb.push_back(model(o, ea, eb, dif, u, rf));
        @(negedge clock);
        op = o; exp_a = ea; exp_b = eb; exp_dif = dif; ula = u; round_fract = rf;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1; mrst = 0; got = 1'b0;
        chk("busy_exp", busy, 1);
        chk("zero_cleared", zero, 0);
        while (!got && cyc < 64) begin
            sr_log[cyc] = sinalShiftRes;
            id_log[cyc] = sinalIncOrDec;
            if (mult_reset) mrst++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (poke && cyc == 3) start = 1'b1;
                if (poke && cyc == 4) start = 1'b0;
                @(negedge clock);
                cyc++;
            end
        end
        start = 1'b0;
        if (!got) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk("latency", cyc, e.lat);
        chk("mux1", sinalMuxFP1, e.sel);
        chk("mux2", sinalMuxFP2, e.sel);
        chk("mux3", sinalMuxFP3, !e.sel);
        chk("mux45", {sinalMuxFP4, sinalMuxFP5}, 2'b11);
        chk("shift_fract", sinalShiftFract, e.sf);
        chk("norm_shift", (cyc >= 3) ? sr_log[cyc - 3] : 9'h1FF, e.nsr);
        chk("norm_adj", (cyc >= 3) ? id_log[cyc - 3] : 9'h1FF, e.nid);
        chk("final_shift", sr_log[cyc - 1], e.fsr);
        chk("done_shift", sinalShiftRes, e.fsr);
        chk("final_adj", sinalIncOrDec, e.fid);
        chk("round", sinalRound, e.rnd);
        chk("zero", zero, e.zr);
        chk("mult_reset_cycles", mrst, e.mrst);
        @(negedge clock);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("zero_hold", zero, e.zr);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_outputs", {sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4, sinalMuxFP5,
                              sinalShiftFract, sinalShiftRes, sinalIncOrDec, sinalRound,
                              mult_reset, busy, done, zero}, 64'd0);
        reset = 1'b1;

        // Add, a larger; no rounding carry.
        run_op(2'b00, 8'h82, 8'h80, 8'd2, 27'h4000000, 26'd0, 1'b0);
        // Add, b larger, shift saturates at 27.
        run_op(2'b00, 8'h68, 8'h90, 8'd40, 27'h4000000, {23'h7FFFFF, 3'b011}, 1'b0);
        // Multiply with rounding carry.
        run_op(2'b01, 8'h80, 8'h80, 8'd0, 27'h1000000, {23'h7FFFFF, 3'b100}, 1'b0);
        // Zero result suppresses carry and rounding.
        run_op(2'b00, 8'h81, 8'h81, 8'd0, 27'd0, {23'h7FFFFF, 3'b100}, 1'b0);
        // Multiply via a non-add encoding, with a start pulse while busy.
        run_op(2'b11, 8'h10, 8'h7F, 8'd5, 27'h0000123, 26'h0ABCDEF, 1'b1);

        // Reset in the middle of a multiply wait.
        sb.push_back(model(2'b01, 8'h10, 8'h20, 8'd0, 27'h1, 26'd0));
        @(negedge clock);
        op = 2'b01; exp_a = 8'h10; exp_b = 8'h20; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("pre_reset_mux1", sinalMuxFP1, 1);
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4, sinalMuxFP5,
                                    sinalShiftFract, sinalShiftRes, sinalIncOrDec, sinalRound,
                                    mult_reset, busy, done, zero}, 64'd0);
        void'(sb.pop_front());
        @(negedge clock);
        reset = 1'b1;

        // Recovery after the abandoned operation.
        run_op(2'b00, 8'h90, 8'h91, 8'd1, 27'h0800000, 26'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
